// File: rtl/mandel_pkg.sv
// Shared state type, coordinate widths, default frame size and raster step helper
// for the Mandelbrot pixel scheduler.
package mandel_pkg;

    localparam int X_W        = 10;
    localparam int Y_W        = 9;
    localparam int DEF_X_SIZE = 640;
    localparam int DEF_Y_SIZE = 480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [Y_W-1:0] y;
        logic [X_W-1:0] x;
    } raster_pos_t;

    // Next raster position, x fastest, wrapping to (0,0) after the last pixel.
    function automatic raster_pos_t raster_step(input raster_pos_t    pos,
                                                input logic [X_W-1:0] x_max,
                                                input logic [Y_W-1:0] y_max);
        raster_pos_t nxt;
        nxt = pos;
        if (pos.x == x_max) begin
            nxt.x = '0;
            nxt.y = (pos.y == y_max) ? '0 : pos.y + Y_W'(1);
        end else begin
            nxt.x = pos.x + X_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mandel_raster_counter.sv
// Issue-side and retire-side raster position counters; the issue side provides the
// dispatched coordinate and frame end, the retire side provides SOF/EOL/frame end.
module mandel_raster_counter
    import mandel_pkg::*;
#(
    parameter int X_SIZE = DEF_X_SIZE,
    parameter int Y_SIZE = DEF_Y_SIZE
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           issue_adv,
    input  logic           retire_adv,
    output logic [X_W-1:0] issue_x,
    output logic [Y_W-1:0] issue_y,
    output logic           issue_last,
    output logic           retire_sof,
    output logic           retire_eol,
    output logic           retire_last
);

    localparam logic [X_W-1:0] X_MAX = X_W'(X_SIZE - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(Y_SIZE - 1);

    raster_pos_t issue_pos;
    raster_pos_t retire_pos;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_pos  <= '0;
            retire_pos <= '0;
        end else begin
            if (issue_adv)
                issue_pos <= raster_step(issue_pos, X_MAX, Y_MAX);
            if (retire_adv)
                retire_pos <= raster_step(retire_pos, X_MAX, Y_MAX);
        end
    end

    assign issue_x     = issue_pos.x;
    assign issue_y     = issue_pos.y;
    assign issue_last  = (issue_pos.x == X_MAX) && (issue_pos.y == Y_MAX);
    assign retire_sof  = (retire_pos.x == '0) && (retire_pos.y == '0);
    assign retire_eol  = (retire_pos.x == X_MAX);
    assign retire_last = retire_eol && (retire_pos.y == Y_MAX);

endmodule

// File: rtl/mandel_pixel_scheduler.sv
// Round-robin pixel dispatcher for N_ENG iteration engines with in-order AXI-Stream retire.
// Define SCHED_CONTINUOUS_EN to restart the next frame right after the last dispatch.
module mandel_pixel_scheduler
    import mandel_pkg::*;
#(
    parameter int N_ENG  = 4,
    parameter int X_SIZE = DEF_X_SIZE,
    parameter int Y_SIZE = DEF_Y_SIZE,
    parameter int ITER_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic [N_ENG-1:0]        eng_start,
    output logic [X_W-1:0]          eng_x,
    output logic [Y_W-1:0]          eng_y,
    input  logic [N_ENG-1:0]        eng_done,
    input  logic [N_ENG*ITER_W-1:0] eng_iter,
    output logic [ITER_W-1:0]       out_tdata,
    output logic                    out_tvalid,
    input  logic                    out_tready,
    output logic                    out_tuser,
    output logic                    out_tlast,
    output logic                    frame_done
);

    localparam int PTR_W = $clog2(N_ENG);

`ifdef SCHED_CONTINUOUS_EN
    localparam bit CONTINUOUS = 1'b1;
`else
    localparam bit CONTINUOUS = 1'b0;
`endif

    sched_state_t state, state_nxt;

    logic [PTR_W-1:0]  issue_ptr;
    logic [PTR_W-1:0]  retire_ptr;
    logic [N_ENG-1:0]  eng_busy;
    logic [N_ENG-1:0]  slot_full;
    logic [N_ENG-1:0]  capture;
    logic [N_ENG-1:0]  retire_mask;
    logic [ITER_W-1:0] slot_data [N_ENG];

    logic dispatch;
    logic retire;
    logic issue_last;
    logic retire_sof;
    logic retire_eol;
    logic retire_last;

    mandel_raster_counter #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE)
    ) u_raster (
        .clk         (clk),
        .rst         (rst),
        .issue_adv   (dispatch),
        .retire_adv  (retire),
        .issue_x     (eng_x),
        .issue_y     (eng_y),
        .issue_last  (issue_last),
        .retire_sof  (retire_sof),
        .retire_eol  (retire_eol),
        .retire_last (retire_last)
    );

    // Engine k only ever holds pixels k, k+N, ...; waiting on its empty slot keeps retire order.
    assign dispatch    = (state == RUN) && !eng_busy[issue_ptr] && !slot_full[issue_ptr];
    assign eng_start   = dispatch ? (N_ENG'(1) << issue_ptr) : '0;
    assign capture     = eng_done & eng_busy;

    assign out_tvalid  = slot_full[retire_ptr];
    assign out_tdata   = out_tvalid ? slot_data[retire_ptr] : '0;
    assign out_tuser   = out_tvalid && retire_sof;
    assign out_tlast   = out_tvalid && retire_eol;
    assign retire      = out_tvalid && out_tready;
    assign retire_mask = retire ? (N_ENG'(1) << retire_ptr) : '0;

    assign busy        = (state != IDLE);

    // NOTE: next-state gets its default first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (dispatch && issue_last && !CONTINUOUS) state_nxt = DRAIN;
            DRAIN:   if (retire && retire_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            issue_ptr  <= '0;
            retire_ptr <= '0;
            eng_busy   <= '0;
            slot_full  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            if (dispatch)
                issue_ptr <= issue_ptr + PTR_W'(1);
            if (retire)
                retire_ptr <= retire_ptr + PTR_W'(1);
            eng_busy   <= (eng_busy & ~capture) | eng_start;
            slot_full  <= (slot_full | capture) & ~retire_mask;
            frame_done <= retire && retire_last;
        end
    end

    // NOTE: slot payload has no reset; slot_full qualifies it and out_tdata is masked while empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_ENG; i++) begin
            if (capture[i])
                slot_data[i] <= eng_iter[i*ITER_W +: ITER_W];
        end
    end

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Directed bench for mandel_pixel_scheduler: 8x2 frame, 4 engines modelled with fixed latencies.
module tb_mandel_pixel_scheduler;

    localparam int N     = 4;
    localparam int XS    = 8;
    localparam int YS    = 2;
    localparam int IW    = 8;
    localparam int FRAME = XS * YS;

`ifdef SCHED_CONTINUOUS_EN
    localparam int NF = 2;
`else
    localparam int NF = 1;
`endif

    typedef struct {
        int lat0;
        int lat_rest;
        bit rand_ready;
        bit start_mid;
        int exp_first;
        bit chk_b2b;
    } scen_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy;
    logic [N-1:0]      eng_start;
    logic [9:0]        eng_x;
    logic [8:0]        eng_y;
    logic [N-1:0]      eng_done;
    logic [N*IW-1:0]   eng_iter;
    logic [IW-1:0]     out_tdata;
    logic              out_tvalid;
    logic              out_tready;
    logic              out_tuser;
    logic              out_tlast;
    logic              frame_done;

    mandel_pixel_scheduler #(
        .N_ENG  (N),
        .X_SIZE (XS),
        .Y_SIZE (YS),
        .ITER_W (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_x      (eng_x),
        .eng_y      (eng_y),
        .eng_done   (eng_done),
        .eng_iter   (eng_iter),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tuser  (out_tuser),
        .out_tlast  (out_tlast),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Engine and scoreboard model state.
    int           lat [N];
    int           cnt [N];
    int           lx  [N];
    int           ly  [N];
    logic [N-1:0] busy_m;
    logic [N-1:0] slot_m;
    logic [N-1:0] prev_start;
    logic [N-1:0] prev_done;
    int           prev_ret;
    int           disp_cnt;
    int           out_cnt;
    int           fd_cnt;
    int           cyc;
    int           total;
    int           busy_gap;
    int           disp_cyc [64];
    int           hs_cyc   [64];
    bit           rand_ready;
    bit           stalled;
    logic [IW-1:0] st_data;
    logic         st_user;
    logic         st_last;
    bit           last_hs_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [IW-1:0] pix_val(input int x, input int y);
        return IW'((((y * XS + x) * 37) + 11) ^ 'h5A);
    endfunction

    task automatic reset_model();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            lx[i]  = 0;
            ly[i]  = 0;
        end
        for (int i = 0; i < 64; i++) begin
            disp_cyc[i] = -1000;
            hs_cyc[i]   = -1000;
        end
        busy_m       = '0;
        slot_m       = '0;
        prev_start   = '0;
        prev_done    = '0;
        prev_ret     = -1;
        disp_cnt     = 0;
        out_cnt      = 0;
        fd_cnt       = 0;
        busy_gap     = 0;
        stalled      = 1'b0;
        last_hs_prev = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_eng_start"},  32'(eng_start),  32'd0);
        check({tag, "_eng_x"},      32'(eng_x),      32'd0);
        check({tag, "_eng_y"},      32'(eng_y),      32'd0);
        check({tag, "_tvalid"},     32'(out_tvalid), 32'd0);
        check({tag, "_tdata"},      32'(out_tdata),  32'd0);
        check({tag, "_tuser"},      32'(out_tuser),  32'd0);
        check({tag, "_tlast"},      32'(out_tlast),  32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    // One clock cycle: advance the engine model, drive inputs, then sample and score outputs.
    task automatic tick();
        logic [N-1:0]    done_v;
        logic [N*IW-1:0] iter_v;
        logic [N-1:0]    exp_onehot;
        int              e;
        int              pix;
        bit              hs_last;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (prev_start[i]) busy_m[i] = 1'b1;
            if (prev_done[i]) begin
                busy_m[i] = 1'b0;
                slot_m[i] = 1'b1;
            end
        end
        if (prev_ret >= 0) slot_m[prev_ret] = 1'b0;

        done_v = '0;
        iter_v = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    done_v[i]           = 1'b1;
                    iter_v[i*IW +: IW]  = pix_val(lx[i], ly[i]);
                end
            end
        end
        eng_done   = done_v;
        eng_iter   = iter_v;
        prev_done  = done_v;
        out_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;

        prev_start = '0;
        prev_ret   = -1;

        if (eng_start != '0) begin
            e          = disp_cnt % N;
            pix        = disp_cnt % FRAME;
            exp_onehot = N'(1) << e;
            check("dispatch_engine", 32'(eng_start), 32'(exp_onehot));
            check("dispatch_x", 32'(eng_x), 32'(pix % XS));
            check("dispatch_y", 32'(eng_y), 32'(pix / XS));
            check("dispatch_to_free_engine", 32'(busy_m[e] | slot_m[e]), 32'd0);
            lx[e]         = int'(eng_x);
            ly[e]         = int'(eng_y);
            cnt[e]        = lat[e];
            prev_start[e] = 1'b1;
            if (disp_cnt < 64) disp_cyc[disp_cnt] = cyc;
            disp_cnt++;
        end

        if (out_cnt < total && !busy) busy_gap++;

        if (stalled) begin
            check("hold_tvalid", 32'(out_tvalid), 32'd1);
            check("hold_tdata",  32'(out_tdata),  32'(st_data));
            check("hold_tuser",  32'(out_tuser),  32'(st_user));
            check("hold_tlast",  32'(out_tlast),  32'(st_last));
        end

        hs_last = 1'b0;
        if (out_tvalid) begin
            if (out_cnt >= total) begin
`ifndef SCHED_CONTINUOUS_EN
                check("extra_pixel", 32'(out_tvalid), 32'd0);
`endif
            end else if (out_tready) begin
                pix = out_cnt % FRAME;
                check("out_tdata", 32'(out_tdata), 32'(pix_val(pix % XS, pix / XS)));
                check("out_tuser", 32'(out_tuser), 32'(pix == 0));
                check("out_tlast", 32'(out_tlast), 32'((pix % XS) == XS - 1));
                if (out_cnt < 64) hs_cyc[out_cnt] = cyc;
                prev_ret = out_cnt % N;
                hs_last  = (pix == FRAME - 1);
                out_cnt++;
            end
        end
        stalled = out_tvalid && !out_tready;
        st_data = out_tdata;
        st_user = out_tuser;
        st_last = out_tlast;

        if (frame_done) begin
            check("frame_done_after_last_pixel", 32'(last_hs_prev), 32'd1);
            fd_cnt++;
        end
        last_hs_prev = hs_last;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        start      = 1'b0;
        eng_done   = '0;
        eng_iter   = '0;
        out_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_scenario(input scen_t s, input bit do_reset);
        int c0;
        int guard;
        if (do_reset) apply_reset();
        reset_model();
        lat[0] = s.lat0;
        for (int i = 1; i < N; i++) lat[i] = s.lat_rest;
        rand_ready = s.rand_ready;
        total      = NF * FRAME;

        start = 1'b1;
        tick();
        start = 1'b0;
        c0    = cyc;
        check("first_dispatch_next_cycle", 32'(disp_cnt), 32'd1);

        guard = 0;
        while ((out_cnt < total || fd_cnt < NF) && guard < 2000) begin
            if (s.start_mid && cyc == c0 + 5) start = 1'b1;
            tick();
            start = 1'b0;
            guard++;
        end
        check("pixels_delivered", 32'(out_cnt), 32'(total));
        check("frame_done_count", 32'(fd_cnt), 32'(NF));
        check("no_idle_gap", 32'(busy_gap), 32'd0);
`ifndef SCHED_CONTINUOUS_EN
        repeat (3) tick();
        check("idle_after_frame", 32'(busy), 32'd0);
        check("single_frame_done", 32'(fd_cnt), 32'd1);
`endif
        if (s.exp_first >= 0)
            check("first_pixel_latency", 32'(hs_cyc[0] - disp_cyc[0]), 32'(s.exp_first));
        if (s.chk_b2b) begin
            for (int k = 1; k < N; k++)
                check("back_to_back_retire", 32'(hs_cyc[k] - hs_cyc[0]), 32'(k));
        end
    endtask

    scen_t scen [4];

    initial begin
        int guard;
        cyc        = 0;
        rst        = 1'b1;
        start      = 1'b0;
        eng_done   = '0;
        eng_iter   = '0;
        out_tready = 1'b0;
        rand_ready = 1'b0;
        total      = 0;
        reset_model();
        for (int i = 0; i < N; i++) lat[i] = 3;

        //         lat0 rest rand mid first b2b
        scen[0] = '{3,   3,   0,   0,  4,   1};
        scen[1] = '{20,  2,   0,   0,  21,  1};
        scen[2] = '{3,   3,   1,   0,  -1,  0};
        scen[3] = '{5,   1,   0,   1,  6,   1};

        for (int s = 0; s < 4; s++)
            run_scenario(scen[s], 1'b1);

        // Reset in the middle of a frame, then a stale completion, then a fresh frame.
        apply_reset();
        reset_model();
        for (int i = 0; i < N; i++) lat[i] = 3;
        rand_ready = 1'b0;
        total      = FRAME;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (disp_cnt < 5 && guard < 60) begin
            tick();
            guard++;
        end
        check("five_dispatched", 32'(disp_cnt), 32'd5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("midframe_reset");
        rst      = 1'b0;
        eng_done = '1;
        eng_iter = {N{8'hC3}};
        @(posedge clk);
        #1;
        eng_done = '0;
        eng_iter = '0;
        repeat (2) @(posedge clk);
        #1;
        check("late_done_no_tvalid", 32'(out_tvalid), 32'd0);
        check("late_done_idle", 32'(busy), 32'd0);
        check("late_done_no_dispatch", 32'(eng_start), 32'd0);
        run_scenario(scen[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
